// File: rtl/motion_update_broadcaster.sv
// motion_update_broadcaster
//   Upstream stage of the per-cell position/velocity caches. Accepts updated
//   particle records from the motion update unit, wraps each position into
//   the periodic box, computes the destination cell, and broadcasts one
//   record per cycle to every cell cache framed by motion_update_enable.
//   After the last record, enable is held low for three cycles so that every
//   cache can commit its particle count and swap buffers. out_done then
//   pulses for one cycle.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   in_start              one-cycle pulse that begins a pass (taken in IDLE only)
//   in_valid/in_ready     record handshake; in_last marks the final record
//   in_pos, in_vel        {z,y,x} signed fixed-point components
//   in_src_cell           {x,y,z} cell the particle came from
//   motion_update_enable  framing to the caches (high while the pass streams)
//   out_pos_data          wrapped position {z,y,x}
//   out_vel_data          velocity {z,y,x}, passed through unchanged
//   out_dst_cell          {x,y,z} destination cell, 1-based
//   out_data_valid        broadcast record valid (data outputs are zero otherwise)
//   out_particle_count    records broadcast this pass (saturating)
//   out_migrated_count    broadcast records whose cell changed (saturating)
//   out_range_error       sticky: some component was outside [-L, 2L)
//   out_done              one-cycle pulse once the pass is committed
module motion_update_broadcaster #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned FRAC_WIDTH    = 16,
    parameter int unsigned CELL_ID_WIDTH = 4,
    parameter int unsigned CELL_NUM_X    = 4,
    parameter int unsigned CELL_NUM_Y    = 4,
    parameter int unsigned CELL_NUM_Z    = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_start,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic                       in_last,
    input  logic [3*DATA_WIDTH-1:0]    in_pos,
    input  logic [3*DATA_WIDTH-1:0]    in_vel,
    input  logic [3*CELL_ID_WIDTH-1:0] in_src_cell,
    output logic                       motion_update_enable,
    output logic [3*DATA_WIDTH-1:0]    out_pos_data,
    output logic [3*DATA_WIDTH-1:0]    out_vel_data,
    output logic [3*CELL_ID_WIDTH-1:0] out_dst_cell,
    output logic                       out_data_valid,
    output logic [CNT_WIDTH-1:0]       out_particle_count,
    output logic [CNT_WIDTH-1:0]       out_migrated_count,
    output logic                       out_range_error,
    output logic                       out_done
);

    localparam int unsigned DW  = DATA_WIDTH;
    localparam int unsigned CW  = CELL_ID_WIDTH;
    // Three guard bits so that -L and 2L are representable without overflow.
    localparam int unsigned EXT = DATA_WIDTH + 3;

    localparam logic signed [EXT-1:0] L_X = signed'(EXT'(CELL_NUM_X) << FRAC_WIDTH);
    localparam logic signed [EXT-1:0] L_Y = signed'(EXT'(CELL_NUM_Y) << FRAC_WIDTH);
    localparam logic signed [EXT-1:0] L_Z = signed'(EXT'(CELL_NUM_Z) << FRAC_WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACTIVE,
        S_DRAIN,
        S_GUARD,
        S_DONE
    } state_t;

    // ------------------------------------------------------------------
    // Helpers
    // ------------------------------------------------------------------
    function automatic logic signed [EXT-1:0] sext(input logic [DW-1:0] p);
        return signed'({{3{p[DW-1]}}, p});
    endfunction

    function automatic logic [DW-1:0] wrap_comp(input logic [DW-1:0] p,
                                                input logic signed [EXT-1:0] l);
        logic signed [EXT-1:0] pe;
        logic signed [EXT-1:0] w;
        pe = sext(p);
        w  = pe;
        if (pe < 0) begin
            w = pe + l;
        end else if (pe >= l) begin
            w = pe - l;
        end
        return w[DW-1:0];
    endfunction

    function automatic logic out_of_range(input logic [DW-1:0] p,
                                          input logic signed [EXT-1:0] l);
        logic signed [EXT-1:0] pe;
        pe = sext(p);
        return (pe < -l) || (pe >= (l <<< 1));
    endfunction

    // Cell index from a wrapped component; only an out-of-range input can
    // land beyond the last cell, which is then pinned to the last cell.
    function automatic logic [CW-1:0] cell_idx(input logic [DW-1:0] w,
                                               input int unsigned n);
        logic [DW-1:0] sh;
        logic [CW-1:0] idx;
        sh  = (w >> FRAC_WIDTH) + DW'(1);
        idx = sh[CW-1:0];
        if (32'(idx) > n) begin
            idx = CW'(n);
        end
        return idx;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_t                 state_q,   state_d;
    logic [1:0]             timer_q,   timer_d;

    logic                   s1_valid_q, s1_valid_d;
    logic [3*DW-1:0]        s1_pos_q,   s1_pos_d;
    logic [3*DW-1:0]        s1_vel_q,   s1_vel_d;
    logic [3*CW-1:0]        s1_src_q,   s1_src_d;
    logic                   s1_err_q,   s1_err_d;

    logic                   s2_valid_q, s2_valid_d;
    logic [3*DW-1:0]        s2_pos_q,   s2_pos_d;
    logic [3*DW-1:0]        s2_vel_q,   s2_vel_d;
    logic [3*CW-1:0]        s2_dst_q,   s2_dst_d;
    logic                   s2_mig_q,   s2_mig_d;

    logic [CNT_WIDTH-1:0]   cnt_q,     cnt_d;
    logic [CNT_WIDTH-1:0]   mig_cnt_q, mig_cnt_d;
    logic                   err_q,     err_d;

    logic                   accept;
    logic [3*CW-1:0]        dst_cell;

    assign in_ready = (state_q == S_ACTIVE);
    assign accept   = in_valid && in_ready;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        case (state_q)
            S_IDLE: begin
                if (in_start) begin
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (accept && in_last) begin
                    state_d = S_DRAIN;
                    timer_d = '0;
                end
            end
            // Two cycles cover S1 and S2 emptying; enable drops after that.
            S_DRAIN: begin
                if (timer_q == 2'd1) begin
                    state_d = S_GUARD;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            S_GUARD: begin
                if (timer_q == 2'd2) begin
                    state_d = S_DONE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 2'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                timer_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // S1: wrap and range check
    // ------------------------------------------------------------------
    always_comb begin
        s1_valid_d = accept;
        s1_pos_d   = '0;
        s1_vel_d   = '0;
        s1_src_d   = '0;
        s1_err_d   = 1'b0;
        if (accept) begin
            s1_pos_d[DW-1:0]      = wrap_comp(in_pos[DW-1:0],      L_X);
            s1_pos_d[2*DW-1:DW]   = wrap_comp(in_pos[2*DW-1:DW],   L_Y);
            s1_pos_d[3*DW-1:2*DW] = wrap_comp(in_pos[3*DW-1:2*DW], L_Z);
            s1_vel_d = in_vel;
            s1_src_d = in_src_cell;
            s1_err_d = out_of_range(in_pos[DW-1:0],      L_X)
                     | out_of_range(in_pos[2*DW-1:DW],   L_Y)
                     | out_of_range(in_pos[3*DW-1:2*DW], L_Z);
        end
    end

    // ------------------------------------------------------------------
    // S2: destination cell and migration compare
    // ------------------------------------------------------------------
    always_comb begin
        dst_cell = '0;
        dst_cell[3*CW-1:2*CW] = cell_idx(s1_pos_q[DW-1:0],      CELL_NUM_X);
        dst_cell[2*CW-1:CW]   = cell_idx(s1_pos_q[2*DW-1:DW],   CELL_NUM_Y);
        dst_cell[CW-1:0]      = cell_idx(s1_pos_q[3*DW-1:2*DW], CELL_NUM_Z);

        s2_valid_d = s1_valid_q;
        s2_pos_d   = '0;
        s2_vel_d   = '0;
        s2_dst_d   = '0;
        s2_mig_d   = 1'b0;
        if (s1_valid_q) begin
            s2_pos_d = s1_pos_q;
            s2_vel_d = s1_vel_q;
            s2_dst_d = dst_cell;
            s2_mig_d = (dst_cell != s1_src_q);
        end
    end

    // ------------------------------------------------------------------
    // Statistics
    // ------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        mig_cnt_d = mig_cnt_q;
        err_d     = err_q | (s1_valid_q & s1_err_q);
        if (state_q == S_IDLE && in_start) begin
            cnt_d     = '0;
            mig_cnt_d = '0;
            err_d     = 1'b0;
        end else if (s2_valid_q) begin
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_WIDTH'(1);
            end
            if (s2_mig_q && mig_cnt_q != '1) begin
                mig_cnt_d = mig_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            timer_q    <= '0;
            s1_valid_q <= 1'b0;
            s1_pos_q   <= '0;
            s1_vel_q   <= '0;
            s1_src_q   <= '0;
            s1_err_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_pos_q   <= '0;
            s2_vel_q   <= '0;
            s2_dst_q   <= '0;
            s2_mig_q   <= 1'b0;
            cnt_q      <= '0;
            mig_cnt_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            timer_q    <= timer_d;
            s1_valid_q <= s1_valid_d;
            s1_pos_q   <= s1_pos_d;
            s1_vel_q   <= s1_vel_d;
            s1_src_q   <= s1_src_d;
            s1_err_q   <= s1_err_d;
            s2_valid_q <= s2_valid_d;
            s2_pos_q   <= s2_pos_d;
            s2_vel_q   <= s2_vel_d;
            s2_dst_q   <= s2_dst_d;
            s2_mig_q   <= s2_mig_d;
            cnt_q      <= cnt_d;
            mig_cnt_q  <= mig_cnt_d;
            err_q      <= err_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign motion_update_enable = (state_q == S_ACTIVE) || (state_q == S_DRAIN);
    assign out_pos_data         = s2_pos_q;
    assign out_vel_data         = s2_vel_q;
    assign out_dst_cell         = s2_dst_q;
    assign out_data_valid       = s2_valid_q;
    assign out_particle_count   = cnt_q;
    assign out_migrated_count   = mig_cnt_q;
    assign out_range_error      = err_q;
    assign out_done             = (state_q == S_DONE);

endmodule

// File: tb/tb_motion_update_broadcaster.sv
module tb_motion_update_broadcaster;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_start;
    logic         in_valid;
    logic         in_ready;
    logic         in_last;
    logic [95:0]  in_pos;
    logic [95:0]  in_vel;
    logic [11:0]  in_src_cell;
    logic         motion_update_enable;
    logic [95:0]  out_pos_data;
    logic [95:0]  out_vel_data;
    logic [11:0]  out_dst_cell;
    logic         out_data_valid;
    logic [15:0]  out_particle_count;
    logic [15:0]  out_migrated_count;
    logic         out_range_error;
    logic         out_done;

    motion_update_broadcaster #(
        .DATA_WIDTH   (32),
        .FRAC_WIDTH   (16),
        .CELL_ID_WIDTH(4),
        .CELL_NUM_X   (4),
        .CELL_NUM_Y   (4),
        .CELL_NUM_Z   (1),
        .CNT_WIDTH    (16)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .in_start            (in_start),
        .in_valid            (in_valid),
        .in_ready            (in_ready),
        .in_last             (in_last),
        .in_pos              (in_pos),
        .in_vel              (in_vel),
        .in_src_cell         (in_src_cell),
        .motion_update_enable(motion_update_enable),
        .out_pos_data        (out_pos_data),
        .out_vel_data        (out_vel_data),
        .out_dst_cell        (out_dst_cell),
        .out_data_valid      (out_data_valid),
        .out_particle_count  (out_particle_count),
        .out_migrated_count  (out_migrated_count),
        .out_range_error     (out_range_error),
        .out_done            (out_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [95:0] pos;
        logic [95:0] vel;
        logic [11:0] dst;
        logic        mig;
        logic        last;
        int          due;
    } rec_t;

    rec_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc      = 0;
    int   done_cyc = -100;
    int   exp_cnt  = 0;
    int   exp_mig  = 0;
    logic exp_err  = 1'b0;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Reference wrap / cell computation for one component.
    task automatic model_comp(input logic [31:0] p, input int cells,
                              output logic [31:0] w, output logic err, output logic [3:0] idx);
        longint v;
        longint l;
        int unsigned i;
        v   = longint'(signed'(p));
        l   = longint'(cells) * 65536;
        err = (v < -l) || (v >= 2 * l);
        if (v < 0) v = v + l;
        else if (v >= l) v = v - l;
        w = v[31:0];
        i = (w >> 16) + 1;
        i = i % 16;
        if (i > cells) i = cells;
        idx = i[3:0];
    endtask

    task automatic push_expected(input logic [95:0] pos, input logic [95:0] vel,
                                 input logic [11:0] src, input logic last);
        rec_t r;
        logic [31:0] wx, wy, wz;
        logic ex, ey, ez;
        logic [3:0] ix, iy, iz;
        model_comp(pos[31:0],  4, wx, ex, ix);
        model_comp(pos[63:32], 4, wy, ey, iy);
        model_comp(pos[95:64], 1, wz, ez, iz);
        r.pos  = {wz, wy, wx};
        r.vel  = vel;
        r.dst  = {ix, iy, iz};
        r.mig  = (r.dst != src);
        r.last = last;
        r.due  = cyc + 2;
        if (ex || ey || ez) exp_err = 1'b1;
        q.push_back(r);
    endtask

    // Monitor / scoreboard: sample on the falling edge.
    always @(negedge clk) begin
        rec_t e;
        cyc++;
        if (out_data_valid) begin
            if (q.size() == 0) begin
                check("unexpected_valid", 1, 0);
            end else begin
                e = q.pop_front();
                check("latency", cyc, e.due);
                check("pos", out_pos_data, e.pos);
                check("vel", out_vel_data, e.vel);
                check("dst", out_dst_cell, e.dst);
                check("enable_on_valid", motion_update_enable, 1);
                if (exp_cnt < 65535) exp_cnt++;
                if (e.mig && exp_mig < 65535) exp_mig++;
                if (e.last) done_cyc = cyc + 4;
            end
        end else begin
            check("idle_zero", {out_pos_data, out_vel_data, out_dst_cell}, 0);
        end
        if (cyc > done_cyc - 4 && cyc <= done_cyc)
            check("guard_enable_low", motion_update_enable, 0);
        if (out_done || cyc == done_cyc)
            check("done_timing", out_done, cyc == done_cyc);
        if (rst) begin
            q.delete();
            exp_cnt  = 0;
            exp_mig  = 0;
            exp_err  = 1'b0;
            done_cyc = -100;
        end else begin
            if (in_start) begin
                exp_cnt = 0;
                exp_mig = 0;
                exp_err = 1'b0;
            end
            if (in_valid && in_ready) push_expected(in_pos, in_vel, in_src_cell, in_last);
        end
    end

    // Driver tasks: always entered and left at posedge + 1.
    task automatic start_pass();
        in_start = 1'b1;
        @(posedge clk); #1;
        in_start = 1'b0;
        check("start_ready", in_ready, 1);
        check("start_enable", motion_update_enable, 1);
    endtask

    task automatic send(input logic [95:0] pos, input logic [95:0] vel,
                        input logic [11:0] src, input logic last);
        int n = 0;
        in_pos = pos; in_vel = vel; in_src_cell = src; in_last = last; in_valid = 1'b1;
        while (!in_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) check("ready_timeout", 0, 1);
        check("enable_active", motion_update_enable, 1);
        @(posedge clk); #1;
    endtask

    task automatic idle_in();
        in_valid = 1'b0; in_last = 1'b0;
    endtask

    task automatic wait_done(input int exp_count);
        int n = 0;
        idle_in();
        while (!out_done && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        if (!out_done) check("done_timeout", 0, 1);
        check("particle_count", out_particle_count, exp_cnt);
        check("particle_count_abs", out_particle_count, exp_count);
        check("migrated_count", out_migrated_count, exp_mig);
        check("range_error", out_range_error, exp_err);
        @(posedge clk); #1;
        check("ready_after_done", in_ready, 0);
    endtask

    function automatic logic [31:0] rnd_comp(input int cells);
        int l = cells * 65536;
        int r = int'($urandom_range(0, 3 * l - 1)) - l;
        return r;
    endfunction

    function automatic logic [95:0] rnd_pos();
        return {rnd_comp(1), rnd_comp(4), rnd_comp(4)};
    endfunction

    function automatic logic [11:0] rnd_src();
        logic [3:0] x = 4'($urandom_range(1, 4));
        logic [3:0] y = 4'($urandom_range(1, 4));
        return {x, y, 4'd1};
    endfunction

    localparam logic [31:0] Y1 = 32'h0001_0000;
    localparam logic [31:0] Z1 = 32'h0000_4000;
    localparam logic [11:0] SRC321 = {4'd3, 4'd2, 4'd1};

    initial begin
        rst = 1'b1; in_start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
        in_pos = '0; in_vel = '0; in_src_cell = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_ctrl", {in_ready, motion_update_enable, out_data_valid, out_done, out_range_error}, 0);
        check("reset_data", {out_pos_data, out_vel_data, out_dst_cell}, 0);
        check("reset_counts", {out_particle_count, out_migrated_count}, 0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Single particle, no wrap, no migration.
        start_pass();
        send({Z1, Y1, 32'h0002_8000}, 96'h0000_0003_0000_0002_0000_0001, SRC321, 1'b1);
        wait_done(1);
        check("single_mig_zero", out_migrated_count, 0);

        // Negative wrap, upper wrap, out-of-range in one pass.
        start_pass();
        send({Z1, Y1, 32'hFFFF_8000}, 96'h1, SRC321, 1'b0);
        send({Z1, Y1, 32'h0004_4000}, 96'h2, SRC321, 1'b0);
        send({Z1, Y1, 32'h0009_0000}, 96'h3, SRC321, 1'b1);
        wait_done(3);
        check("wrap_range_error_set", out_range_error, 1);

        // Burst of 8 back-to-back; range flag must be clear for this pass.
        start_pass();
        check("range_cleared_on_start", out_range_error, 0);
        for (int i = 0; i < 8; i++)
            send(rnd_pos(), {$urandom, $urandom, $urandom}, rnd_src(), i == 7);
        wait_done(8);

        // Gapped input.
        start_pass();
        for (int i = 0; i < 6; i++) begin
            send(rnd_pos(), {$urandom, $urandom, $urandom}, rnd_src(), i == 5);
            if (i != 5) begin
                idle_in();
                repeat (i % 3 + 1) begin
                    @(posedge clk); #1;
                    check("gap_enable_high", motion_update_enable, 1);
                end
            end
        end
        wait_done(6);

        // Reset after three accepts of a burst.
        start_pass();
        for (int i = 0; i < 3; i++)
            send(rnd_pos(), {$urandom, $urandom, $urandom}, rnd_src(), 1'b0);
        rst = 1'b1;
        idle_in();
        @(posedge clk); #1;
        check("midrst_ctrl", {in_ready, motion_update_enable, out_data_valid, out_done, out_range_error}, 0);
        check("midrst_data", {out_pos_data, out_vel_data, out_dst_cell}, 0);
        check("midrst_counts", {out_particle_count, out_migrated_count}, 0);
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // Clean pass after reset.
        start_pass();
        send({Z1, Y1, 32'hFFFF_8000}, 96'h55, SRC321, 1'b0);
        send({Z1, Y1, 32'h0002_8000}, 96'h66, SRC321, 1'b1);
        wait_done(2);
        check("post_reset_mig", out_migrated_count, 1);
        check("scoreboard_empty", q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
